// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine for FrameLink traffic. Each cycle it folds the valid bytes of one word
// into the CRC and presents each finished frame CRC through a single-entry valid/ready result register.
module crc32_stream #(
    parameter int          DATA_WIDTH = 64,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
    parameter bit          REFLECT    = 1'b1,
    localparam int         NBYTES     = DATA_WIDTH / 8,
    localparam int         REM_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic [REM_W-1:0]      RX_REM,
    input  logic                  RX_SOF_N,
    input  logic                  RX_EOF_N,
    input  logic                  RX_SRC_RDY_N,
    output logic                  RX_DST_RDY_N,
    output logic [31:0]           CRC_DATA,
    output logic                  CRC_VLD,
    input  logic                  CRC_RDY,
    output logic                  ERR
);

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    localparam logic [31:0] POLY_R = rev32(POLY);
    // In reflected mode the register lives bit-reversed, so the seed is reversed too.
    localparam logic [31:0] SEED   = REFLECT ? rev32(INIT) : INIT;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        if (REFLECT) begin
            r = c ^ {24'd0, b};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
        end else begin
            r = c ^ {b, 24'd0};
            for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] res_q, res_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;

    logic        acc, sof, eof;
    logic [31:0] chain;

    assign sof          = ~RX_SOF_N;
    assign eof          = ~RX_EOF_N;
    assign RX_DST_RDY_N = vld_q & ~CRC_RDY;
    assign acc          = ~RX_SRC_RDY_N & ~RX_DST_RDY_N;

    // Unrolled byte chain; an SOF word always starts from the seed, whatever the current state.
    always_comb begin
        chain = sof ? SEED : crc_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (!eof || (i <= int'(RX_REM))) chain = crc_byte(chain, RX_DATA[8*i +: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        res_d   = res_q;
        vld_d   = vld_q & ~CRC_RDY;
        err_d   = 1'b0;
        if (acc) begin
            if (sof || state_q == RUN) begin
                if (sof && state_q == RUN) err_d = 1'b1;
                if (eof) begin
                    res_d   = chain ^ XOROUT;
                    vld_d   = 1'b1;
                    crc_d   = SEED;
                    state_d = IDLE;
                end else begin
                    crc_d   = chain;
                    state_d = RUN;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            crc_q   <= SEED;
            res_q   <= 32'd0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    assign CRC_DATA = res_q;
    assign CRC_VLD  = vld_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Directed bench for crc32_stream: a 64-bit instance runs the frame sequences, a 32-bit
// instance covers narrow-word results; inputs change and outputs are sampled on the falling edge.
module tb_crc32_stream;

    localparam logic [63:0] W0 = 64'h3837363534333231;  // "12345678"
    localparam logic [63:0] W1 = 64'h0000000000000039;  // "9"
    localparam logic [31:0] CRC_CHECK = 32'hCBF43926;
    localparam logic [31:0] CRC_Z4    = 32'h2144DF1C;
    localparam logic [31:0] CRC_Z1    = 32'hD202EF8D;

    logic        CLK, RESET_N;
    logic [63:0] rx_data;
    logic [2:0]  rx_rem;
    logic        rx_sof_n, rx_eof_n, rx_src_rdy_n, rx_dst_rdy_n;
    logic [31:0] crc_data;
    logic        crc_vld, crc_rdy, err;

    logic [31:0] d32_data;
    logic [1:0]  d32_rem;
    logic        d32_sof_n, d32_eof_n, d32_src_rdy_n, d32_dst_rdy_n;
    logic [31:0] d32_crc;
    logic        d32_vld, d32_crc_rdy, d32_err;

    int n_asrt = 0;
    int n_fail = 0;

    crc32_stream #(.DATA_WIDTH(64)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(rx_data), .RX_REM(rx_rem),
        .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SRC_RDY_N(rx_src_rdy_n),
        .RX_DST_RDY_N(rx_dst_rdy_n), .CRC_DATA(crc_data), .CRC_VLD(crc_vld),
        .CRC_RDY(crc_rdy), .ERR(err)
    );

    crc32_stream #(.DATA_WIDTH(32)) dut32 (
        .CLK(CLK), .RESET_N(RESET_N), .RX_DATA(d32_data), .RX_REM(d32_rem),
        .RX_SOF_N(d32_sof_n), .RX_EOF_N(d32_eof_n), .RX_SRC_RDY_N(d32_src_rdy_n),
        .RX_DST_RDY_N(d32_dst_rdy_n), .CRC_DATA(d32_crc), .CRC_VLD(d32_vld),
        .CRC_RDY(d32_crc_rdy), .ERR(d32_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic [63:0] d, input logic [2:0] r, input bit s, input bit e);
        rx_data      = d;
        rx_rem       = r;
        rx_sof_n     = ~s;
        rx_eof_n     = ~e;
        rx_src_rdy_n = 1'b0;
    endtask

    task automatic idle();
        rx_src_rdy_n = 1'b1;
        rx_sof_n     = 1'b1;
        rx_eof_n     = 1'b1;
    endtask

    task automatic drive32(input logic [31:0] d, input logic [1:0] r, input bit s, input bit e);
        d32_data      = d;
        d32_rem       = r;
        d32_sof_n     = ~s;
        d32_eof_n     = ~e;
        d32_src_rdy_n = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        crc_rdy = 1'b1;
        rx_data = '0;
        rx_rem  = '0;
        idle();
        d32_data = '0; d32_rem = '0; d32_sof_n = 1'b1; d32_eof_n = 1'b1;
        d32_src_rdy_n = 1'b1; d32_crc_rdy = 1'b1;
        repeat (2) step();

        chk("reset_crc_data", crc_data, 32'd0);
        chk("reset_crc_vld", {31'd0, crc_vld}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_dst_rdy_n", {31'd0, rx_dst_rdy_n}, 32'd0);
        RESET_N = 1'b1;
        step();

        // "123456789" over two words, result one cycle after the EOF word
        drive(W0, 3'd0, 1, 0); step();
        chk("t1_vld_mid", {31'd0, crc_vld}, 32'd0);
        drive(W1, 3'd0, 0, 1); step();
        chk("t1_vld", {31'd0, crc_vld}, 32'd1);
        chk("t1_crc", crc_data, CRC_CHECK);
        idle(); step();
        chk("t1_vld_clr", {31'd0, crc_vld}, 32'd0);

        // back-to-back frames, no stall
        drive(W0, 3'd0, 1, 0); step();
        drive(W1, 3'd0, 0, 1); step();
        chk("t2_crc_a", crc_data, CRC_CHECK);
        chk("t2_dst_a", {31'd0, rx_dst_rdy_n}, 32'd0);
        drive(64'd0, 3'd3, 1, 1); step();
        chk("t2_crc_b", crc_data, CRC_Z4);
        chk("t2_vld_b", {31'd0, crc_vld}, 32'd1);
        idle(); step();
        chk("t2_vld_clr", {31'd0, crc_vld}, 32'd0);

        // consumer stall holds the result and blocks the next frame
        crc_rdy = 1'b0;
        drive(W0, 3'd0, 1, 0); step();
        drive(W1, 3'd0, 0, 1); step();
        chk("t3_crc_a", crc_data, CRC_CHECK);
        chk("t3_stall0", {31'd0, rx_dst_rdy_n}, 32'd1);
        drive(64'd0, 3'd3, 1, 1); step();
        chk("t3_stall1", {31'd0, rx_dst_rdy_n}, 32'd1);
        chk("t3_hold1", crc_data, CRC_CHECK);
        step();
        chk("t3_hold2", crc_data, CRC_CHECK);
        chk("t3_vld_hold", {31'd0, crc_vld}, 32'd1);
        crc_rdy = 1'b1; step();
        chk("t3_crc_b", crc_data, CRC_Z4);
        chk("t3_vld_b", {31'd0, crc_vld}, 32'd1);
        idle(); step();
        chk("t3_vld_clr", {31'd0, crc_vld}, 32'd0);

        // SOF in RUN: error pulse, partial frame discarded, restart
        drive(W0, 3'd0, 1, 0); step();
        chk("t4_err_none", {31'd0, err}, 32'd0);
        drive(W0, 3'd0, 1, 0); step();
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_no_result", {31'd0, crc_vld}, 32'd0);
        drive(W1, 3'd0, 0, 1); step();
        chk("t4_err_one", {31'd0, err}, 32'd0);
        chk("t4_crc", crc_data, CRC_CHECK);
        idle(); step();

        // word without SOF in IDLE is dropped with an error
        drive(W1, 3'd0, 0, 1); step();
        chk("t5_err", {31'd0, err}, 32'd1);
        chk("t5_no_result", {31'd0, crc_vld}, 32'd0);
        idle(); step();
        chk("t5_err_clr", {31'd0, err}, 32'd0);
        chk("t5_still_none", {31'd0, crc_vld}, 32'd0);

        // async reset with a pending result, then mid-frame
        crc_rdy = 1'b0;
        drive(64'd0, 3'd3, 1, 1); step();
        idle();
        chk("t6_pending", crc_data, CRC_Z4);
        RESET_N = 1'b0; #1;
        chk("t6_rst_vld", {31'd0, crc_vld}, 32'd0);
        chk("t6_rst_data", crc_data, 32'd0);
        chk("t6_rst_dst", {31'd0, rx_dst_rdy_n}, 32'd0);
        step(); step();
        RESET_N = 1'b1;
        crc_rdy = 1'b1;
        drive(W0, 3'd0, 1, 0); step();
        RESET_N = 1'b0;
        idle(); step(); step();
        RESET_N = 1'b1;
        drive(W0, 3'd0, 1, 0); step();
        chk("t6_err_none", {31'd0, err}, 32'd0);
        drive(W1, 3'd0, 0, 1); step();
        chk("t6_crc", crc_data, CRC_CHECK);
        chk("t6_vld", {31'd0, crc_vld}, 32'd1);
        idle(); step();

        // 32-bit word width: four zero bytes, then a single zero byte
        drive32(32'd0, 2'd3, 1, 1); step();
        chk("w32_z4", d32_crc, CRC_Z4);
        chk("w32_vld", {31'd0, d32_vld}, 32'd1);
        drive32(32'd0, 2'd0, 1, 1); step();
        chk("w32_z1", d32_crc, CRC_Z1);
        d32_src_rdy_n = 1'b1; step();
        chk("w32_vld_clr", {31'd0, d32_vld}, 32'd0);
        chk("w32_err", {31'd0, d32_err}, 32'd0);
        chk("w32_dst", {31'd0, d32_dst_rdy_n}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
